// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM states, handshake levels and iteration count.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int unsigned DIV_CYCLES = 32;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {R,Q} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W:0]   r_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W:0]   r_o,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;

    always_comb begin
        shifted = {r_i, q_i[DATA_W-1]};
        trial   = shifted - {2'b00, divisor_i};
        // R < divisor on entry, so the top bit of trial is a pure borrow flag.
        if (trial[DATA_W+1]) begin
            r_o = shifted[DATA_W:0];
            q_o = {q_i[DATA_W-2:0], 1'b0};
        end else begin
            r_o = trial[DATA_W:0];
            q_o = {q_i[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider serving DIV/DIVU; result is {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     r_q, r_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                signed_q, signed_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     step_r;
    logic [DATA_W-1:0]   step_q;
    logic [DATA_W-1:0]   mag1, mag2, quo, rem;
    logic                unused_r_msb;

    div_step #(.DATA_W(DATA_W)) u_step (
        .r_i       (r_q),
        .q_i       (q_q),
        .divisor_i (dvsr_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        dvsr_d   = dvsr_q;
        signed_d = signed_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;

        mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quo  = (signed_q && (sign1_q ^ sign2_q)) ? -q_q : q_q;
        rem  = (signed_q && sign1_q) ? -r_q[DATA_W-1:0] : r_q[DATA_W-1:0];
        unused_r_msb = r_q[DATA_W];

        unique case (state_q)
            DIV_IDLE: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                cnt_d    = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d  = DIV_ON;
                        r_d      = '0;
                        q_d      = mag1;
                        dvsr_d   = mag2;
                        signed_d = signed_div_i;
                        sign1_d  = opdata1_i[DATA_W-1];
                        sign2_d  = opdata2_i[DATA_W-1];
                    end
                end
            end
            DIV_BYZERO: begin
                // One cycle clears the datapath, the next reports the zero result.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                    r_d   = '0;
                    q_d   = '0;
                end else begin
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultReady;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_IDLE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    result_d = {rem, quo};
                    ready_d  = DivResultReady;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DivStop) begin
                    state_d  = DIV_IDLE;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            dvsr_q   <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            dvsr_q   <= dvsr_d;
            signed_q <= signed_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit with hand-computed results and latencies.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks;
    int n_fail;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge is the first tick; lat = edges from accept until ready_o seen high (-1 on timeout).
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom | 32'h1;
        signed_div_i = ~sgn;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ready_o) begin
                lat = i;
                break;
            end
        end
        res = result_o;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        n_checks++;
        if (result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
        n_checks++;
        if (dut.state_q !== DIV_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, DIV_IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_divu_basic();
        int          lat;
        logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, lat, res);
        n_checks++;
        if (lat !== DIV_CYCLES + 1) begin n_fail++; $display("FAIL divu_latency got=%0d exp=%0d", lat, DIV_CYCLES + 1); end
        n_checks++;
        if (res !== {32'h00000002, 32'h0000000E}) begin n_fail++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'h00000002, 32'h0000000E}); end
        release_start();
    endtask

    task automatic test_signed();
        int          lat;
        logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, res);
        n_checks++;
        if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_m7_2 got=%h exp=%h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
        release_start();
        do_div(1'b0, 32'hFFFFFFF9, 32'd2, lat, res);
        n_checks++;
        if (res !== {32'h00000001, 32'h7FFFFFFC}) begin n_fail++; $display("FAIL divu_fff9_2 got=%h exp=%h", res, {32'h00000001, 32'h7FFFFFFC}); end
        release_start();
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
        n_checks++;
        if (res !== {32'h00000001, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL div_7_m2 got=%h exp=%h", res, {32'h00000001, 32'hFFFFFFFD}); end
        release_start();
        do_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, lat, res);
        n_checks++;
        if (res !== {32'hFFFFFFFF, 32'h00000003}) begin n_fail++; $display("FAIL div_m7_m2 got=%h exp=%h", res, {32'hFFFFFFFF, 32'h00000003}); end
        release_start();
    endtask

    task automatic test_boundaries();
        int          lat;
        logic [63:0] res;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        n_checks++;
        if (res !== {32'h00000000, 32'h80000000}) begin n_fail++; $display("FAIL div_overflow got=%h exp=%h", res, {32'h00000000, 32'h80000000}); end
        release_start();
        do_div(1'b0, 32'hFFFFFFFF, 32'h00000010, lat, res);
        n_checks++;
        if (res !== {32'h0000000F, 32'h0FFFFFFF}) begin n_fail++; $display("FAIL divu_max_16 got=%h exp=%h", res, {32'h0000000F, 32'h0FFFFFFF}); end
        release_start();
    endtask

    task automatic test_div_by_zero();
        int          lat;
        logic [63:0] res;
        for (int m = 0; m < 2; m++) begin
            do_div(m[0], 32'h12345678, 32'h0, lat, res);
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL byzero_latency mode=%0d got=%0d exp=2", m, lat); end
            n_checks++;
            if (res !== 64'h0) begin n_fail++; $display("FAIL byzero_result mode=%0d got=%h exp=0", m, res); end
            release_start();
        end
    endtask

    task automatic test_annul();
        int          lat;
        logic [63:0] res;
        logic        saw_ready;
        saw_ready    = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_ready |= ready_o;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        n_checks++;
        if (dut.state_q !== DIV_IDLE) begin n_fail++; $display("FAIL annul_state got=%0d exp=%0d", dut.state_q, DIV_IDLE); end
        n_checks++;
        if (result_o !== 64'h0) begin n_fail++; $display("FAIL annul_result got=%h exp=0", result_o); end
        tick();
        saw_ready |= ready_o;
        n_checks++;
        if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL annul_ready got=%b exp=0", saw_ready); end
        do_div(1'b0, 32'd1000, 32'd3, lat, res);
        n_checks++;
        if (lat !== DIV_CYCLES + 1) begin n_fail++; $display("FAIL annul_restart_latency got=%0d exp=%0d", lat, DIV_CYCLES + 1); end
        n_checks++;
        if (res !== {32'h00000001, 32'd333}) begin n_fail++; $display("FAIL annul_restart_result got=%h exp=%h", res, {32'h00000001, 32'd333}); end
        release_start();
    endtask

    task automatic test_end_hold();
        int          lat;
        logic [63:0] res;
        logic        stable;
        stable = 1'b1;
        do_div(1'b0, 32'd100, 32'd7, lat, res);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready_o !== 1'b1 || result_o !== {32'h00000002, 32'h0000000E}) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL end_hold got=%b exp=1 (last result=%h ready=%b)", stable, result_o, ready_o); end
        start_i = 1'b0;
        tick();
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL end_release_ready got=%b exp=0", ready_o); end
        n_checks++;
        if (result_o !== 64'h0) begin n_fail++; $display("FAIL end_release_result got=%h exp=0", result_o); end
    endtask

    task automatic test_reset_mid();
        signed_div_i = 1'b0;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd10;
        start_i      = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin n_fail++; $display("FAIL midreset_outputs got=%b/%h exp=0/0", ready_o, result_o); end
        n_checks++;
        if (dut.state_q !== DIV_IDLE) begin n_fail++; $display("FAIL midreset_state got=%0d exp=%0d", dut.state_q, DIV_IDLE); end
        n_checks++;
        if (dut.cnt_q !== 6'd0) begin n_fail++; $display("FAIL midreset_counter got=%0d exp=0", dut.cnt_q); end
        rst     = 1'b0;
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundaries();
        test_div_by_zero();
        test_annul();
        test_end_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
